// File: rtl/occupancy_tracker.sv
// Room occupancy tracker: synchronises and edge-detects the entry/exit sensor
// lines, maintains a clamped occupancy count with capacity flags, sticky
// overflow/underflow errors, a registered alarm and a peak-occupancy register.
module occupancy_tracker #(
    parameter int WIDTH       = 4,
    parameter int CAPACITY    = 7,
    parameter int ALMOST_FULL = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ent_in,
    input  logic             ext_in,
    input  logic             enable,
    input  logic             clr_err,
    input  logic             clr_peak,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] peak,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             ovf_err,
    output logic             udf_err,
    output logic             alarm
);

    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0] AF_W  = WIDTH'(ALMOST_FULL);

    // Index 0 = entry sensor, index 1 = exit sensor.
    logic [1:0] sens_in;
    logic [1:0] evt;

    assign sens_in = {ext_in, ent_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   hist_reg;

            // Synchroniser chain plus history flop; history keeps tracking even
            // when events are disabled so nothing is replayed on re-enable.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg <= '0;
                    hist_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], sens_in[gi]};
                    hist_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            assign evt[gi] = sync_reg[SYNC_STAGES-1] & ~hist_reg;
        end
    endgenerate

    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] peak_reg, peak_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic             alarm_reg;
    logic             ent_evt, ext_evt;
    logic             ovf_set, udf_set;

    assign ent_evt = enable & evt[0];
    assign ext_evt = enable & evt[1];

    // Next-state: clamped count update, sticky error flags (set beats clear),
    // and peak tracking against the post-update count.
    always_comb begin
        count_next = count_reg;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (ent_evt && !ext_evt) begin
            if (count_reg < CAP_W) begin
                count_next = count_reg + 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (ext_evt && !ent_evt) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end else begin
                udf_set = 1'b1;
            end
        end
        ovf_next  = ovf_set | (ovf_reg & ~clr_err);
        udf_next  = udf_set | (udf_reg & ~clr_err);
        peak_next = peak_reg;
        if (clr_peak || (count_next > peak_reg)) begin
            peak_next = count_next;
        end
    end

    // State registers; alarm is registered from the next error state so it
    // rises on the same edge as the error flag that causes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            peak_reg  <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
            alarm_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            peak_reg  <= peak_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
            alarm_reg <= ovf_next | udf_next;
        end
    end

    assign count       = count_reg;
    assign peak        = peak_reg;
    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CAP_W);
    assign almost_full = (count_reg >= AF_W);
    assign ovf_err     = ovf_reg;
    assign udf_err     = udf_reg;
    assign alarm       = alarm_reg;

endmodule

// File: tb/tb_occupancy_tracker.sv
// Testbench for occupancy_tracker: table of operations with expected results
// queued per operation and compared once the operation has settled, plus
// hand-written sequences for latency and asynchronous reset.
module tb_occupancy_tracker;

    localparam int OP_ENT        = 0;
    localparam int OP_EXT        = 1;
    localparam int OP_BOTH       = 2;
    localparam int OP_CLR_ERR    = 3;
    localparam int OP_CLR_PEAK   = 4;
    localparam int OP_HOLD_ENT   = 5;
    localparam int OP_DIS_PULSE  = 6;
    localparam int OP_REEN_HIGH  = 7;
    localparam int OP_CLRERR_OVF = 8;

    typedef struct {
        int         op;
        logic [3:0] cnt;
        logic [3:0] pk;
        logic [5:0] flags;   // {empty, full, almost_full, ovf_err, udf_err, alarm}
    } vec_t;

    logic       clk;
    logic       reset;
    logic       ent_in;
    logic       ext_in;
    logic       enable;
    logic       clr_err;
    logic       clr_peak;
    logic [3:0] count;
    logic [3:0] peak;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       ovf_err;
    logic       udf_err;
    logic       alarm;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    occupancy_tracker #(
        .WIDTH(4), .CAPACITY(7), .ALMOST_FULL(6), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .ent_in(ent_in), .ext_in(ext_in),
        .enable(enable), .clr_err(clr_err), .clr_peak(clr_peak),
        .count(count), .peak(peak), .empty(empty), .full(full),
        .almost_full(almost_full), .ovf_err(ovf_err), .udf_err(udf_err),
        .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always end.
    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] dut_flags();
        return {empty, full, almost_full, ovf_err, udf_err, alarm};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int op, input int cnt, input int pk, input logic [5:0] fl);
        vec_t v;
        v.op = op;
        v.cnt = 4'(cnt);
        v.pk = 4'(pk);
        v.flags = fl;
        tbl.push_back(v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic e, input logic x);
        @(negedge clk);
        ent_in = e;
        ext_in = x;
        cycles(3);
        ent_in = 1'b0;
        ext_in = 1'b0;
        cycles(3);
    endtask

    task automatic run_op(input int op);
        case (op)
            OP_ENT:  pulse(1'b1, 1'b0);
            OP_EXT:  pulse(1'b0, 1'b1);
            OP_BOTH: pulse(1'b1, 1'b1);
            OP_CLR_ERR: begin
                @(negedge clk) clr_err = 1'b1;
                @(negedge clk) clr_err = 1'b0;
                cycles(1);
            end
            OP_CLR_PEAK: begin
                @(negedge clk) clr_peak = 1'b1;
                @(negedge clk) clr_peak = 1'b0;
                cycles(1);
            end
            OP_HOLD_ENT: begin
                @(negedge clk) ent_in = 1'b1;
                cycles(20);
                ent_in = 1'b0;
                cycles(4);
            end
            OP_DIS_PULSE: begin
                @(negedge clk) enable = 1'b0;
                pulse(1'b1, 1'b0);
                enable = 1'b1;
                cycles(3);
            end
            OP_REEN_HIGH: begin
                @(negedge clk) enable = 1'b0;
                ent_in = 1'b1;
                cycles(5);
                enable = 1'b1;
                cycles(5);
                ent_in = 1'b0;
                cycles(4);
            end
            OP_CLRERR_OVF: begin
                // Event is live during the cycle ending at the third edge after
                // the input rises; clr_err is held across exactly that edge.
                @(negedge clk) ent_in = 1'b1;
                cycles(2);
                clr_err = 1'b1;
                cycles(1);
                clr_err = 1'b0;
                ent_in = 1'b0;
                cycles(4);
            end
            default: cycles(1);
        endcase
    endtask

    initial begin
        vec_t e;

        // Expected state after each operation.
        for (int i = 2; i <= 7; i++)
            add(OP_ENT, i, i, (i == 7) ? 6'b011000 : (i == 6) ? 6'b001000 : 6'b000000);
        add(OP_ENT,      7, 7, 6'b011101);
        add(OP_EXT,      6, 7, 6'b001101);
        add(OP_CLR_ERR,  6, 7, 6'b001000);
        add(OP_ENT,      7, 7, 6'b011000);
        add(OP_BOTH,     7, 7, 6'b011000);
        for (int i = 6; i >= 0; i--)
            add(OP_EXT, i, 7, (i == 6) ? 6'b001000 : (i == 0) ? 6'b100000 : 6'b000000);
        add(OP_EXT,      0, 7, 6'b100011);
        add(OP_BOTH,     0, 7, 6'b100011);
        add(OP_CLR_ERR,  0, 7, 6'b100000);
        add(OP_BOTH,     0, 7, 6'b100000);
        add(OP_HOLD_ENT, 1, 7, 6'b000000);
        add(OP_DIS_PULSE,1, 7, 6'b000000);
        add(OP_REEN_HIGH,1, 7, 6'b000000);
        for (int i = 2; i <= 5; i++) add(OP_ENT, i, 7, 6'b000000);
        add(OP_CLR_PEAK, 5, 5, 6'b000000);
        add(OP_EXT,      4, 5, 6'b000000);
        add(OP_EXT,      3, 5, 6'b000000);
        add(OP_ENT,      4, 5, 6'b000000);
        add(OP_ENT,      5, 5, 6'b000000);
        add(OP_ENT,      6, 6, 6'b001000);
        add(OP_ENT,      7, 7, 6'b011000);
        add(OP_CLRERR_OVF, 7, 7, 6'b011101);
        add(OP_CLR_ERR,  7, 7, 6'b011000);
        add(OP_EXT,      6, 7, 6'b001000);
        add(OP_EXT,      5, 7, 6'b000000);
        add(OP_EXT,      4, 7, 6'b000000);

        reset = 1'b1;
        ent_in = 1'b0;
        ext_in = 1'b0;
        enable = 1'b1;
        clr_err = 1'b0;
        clr_peak = 1'b0;
        cycles(3);
        chk("reset_count", 8'(count), 8'd0);
        chk("reset_peak", 8'(peak), 8'd0);
        chk("reset_flags", 8'(dut_flags()), 8'b100000);
        $display("reset: count=%0d peak=%0d flags=%b", count, peak, dut_flags());
        reset = 1'b0;
        cycles(2);

        // First entry: count must change exactly two edges after first sample.
        @(negedge clk) ent_in = 1'b1;
        @(posedge clk) #1 chk("lat_edge_k", 8'(count), 8'd0);
        @(posedge clk) #1 chk("lat_edge_k1", 8'(count), 8'd0);
        @(posedge clk) #1 chk("lat_edge_k2", 8'(count), 8'd1);
        $display("latency: count=%0d two edges after sample", count);
        @(negedge clk) ent_in = 1'b0;
        cycles(3);
        chk("first_peak", 8'(peak), 8'd1);

        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i]);
            run_op(tbl[i].op);
            e = exp_q.pop_front();
            chk($sformatf("op%0d_count", i), 8'(count), 8'(e.cnt));
            chk($sformatf("op%0d_peak", i), 8'(peak), 8'(e.pk));
            chk($sformatf("op%0d_flags", i), 8'(dut_flags()), 8'(e.flags));
            $display("op %0d type %0d: count=%0d peak=%0d flags=%b exp %0d/%0d/%b",
                     i, e.op, count, peak, dut_flags(), e.cnt, e.pk, e.flags);
        end

        // Asynchronous reset mid-count with an entry in the sync chain.
        @(negedge clk) ent_in = 1'b1;
        @(posedge clk) #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 8'(count), 8'd0);
        chk("async_rst_peak", 8'(peak), 8'd0);
        chk("async_rst_flags", 8'(dut_flags()), 8'b100000);
        $display("async reset: count=%0d peak=%0d flags=%b", count, peak, dut_flags());
        ent_in = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(6);
        chk("post_rst_no_event", 8'(count), 8'd0);
        $display("release with input low: count=%0d", count);

        // Input already high at reset release counts as a new edge.
        @(negedge clk) reset = 1'b1;
        ent_in = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(6);
        chk("rst_high_input_count", 8'(count), 8'd1);
        chk("rst_high_input_peak", 8'(peak), 8'd1);
        $display("release with input high: count=%0d peak=%0d", count, peak);
        ent_in = 1'b0;
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
